eff_mult_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined signed multiplier among N effect requesters (tremolo gain, volume, mix, …) in the effect chain.
- Accepts at most one multiply per cycle over a valid/ready handshake per requester.
- Returns each full-width product to its originator, tagged by a one-hot response valid, after a fixed latency.
- Replaces per-effect multipliers so the effects share one DSP resource.

---
 rtl/eff_mult_sched_if.sv | 31 +++
 rtl/eff_mult_sched.sv | 121 ++++++++++++
 tb/tb_eff_mult_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eff_mult_sched_if.sv
// ---------------------------------------------------------------------------
// eff_mult_sched_if : request/response bundle for the shared effect multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface eff_mult_sched_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic                        hold;
    logic [N_REQ-1:0]            req_vld;
    logic [N_REQ-1:0]            req_rdy;
    logic [N_REQ*DATA_WIDTH-1:0] req_a;
    logic [N_REQ*DATA_WIDTH-1:0] req_b;
    logic [N_REQ-1:0]            rsp_vld;
    logic [2*DATA_WIDTH-1:0]     rsp_data;
    logic                        busy;

    modport slave (
        input  hold, req_vld, req_a, req_b,
        output req_rdy, rsp_vld, rsp_data, busy
    );

    modport master (
        output hold, req_vld, req_a, req_b,
        input  req_rdy, rsp_vld, rsp_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/eff_mult_sched.sv
// ---------------------------------------------------------------------------
// eff_mult_sched : round-robin scheduler sharing one pipelined signed
//                  multiplier among N_REQ effect requesters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eff_mult_sched #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MULT_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    eff_mult_sched_if.slave  bus
);
    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW    = 2 * DATA_WIDTH;

    logic [TAG_W-1:0]             ptr;
    logic [TAG_W-1:0]             ptr_next;
    logic [N_REQ-1:0]             grant;
    logic                         accept;
    logic [TAG_W-1:0]             gidx;

    logic [MULT_STAGES-1:0]       vld;
    logic [TAG_W-1:0]             tag [MULT_STAGES];
    logic signed [DATA_WIDTH-1:0] op_a;
    logic signed [DATA_WIDTH-1:0] op_b;
    logic signed [PW-1:0]         prod;
    logic [N_REQ-1:0]             rsp_onehot;

    // First pending requester at or after ptr wins; reset also forces no grant.
    always_comb begin : p_grant
        logic [TAG_W-1:0] idx;
        idx    = '0;
        grant  = '0;
        accept = 1'b0;
        gidx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = TAG_W'((int'(ptr) + k) % N_REQ);
            if (!accept && rst_n && !bus.hold && bus.req_vld[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                accept     = 1'b1;
            end
        end
    end

    assign ptr_next    = (gidx == TAG_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    assign bus.req_rdy = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            vld  <= '0;
            op_a <= '0;
            op_b <= '0;
            for (int s = 0; s < MULT_STAGES; s++) begin
                tag[s] <= '0;
            end
        end else begin
            vld[0] <= accept;
            if (accept) begin
                ptr    <= ptr_next;
                tag[0] <= gidx;
                op_a   <= bus.req_a[gidx*DATA_WIDTH +: DATA_WIDTH];
                op_b   <= bus.req_b[gidx*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int s = 1; s < MULT_STAGES; s++) begin
                vld[s] <= vld[s-1];
                tag[s] <= tag[s-1];
            end
        end
    end

    // Both operands sign-extended to full width, so the product never overflows.
    assign prod = $signed({{DATA_WIDTH{op_a[DATA_WIDTH-1]}}, op_a})
                * $signed({{DATA_WIDTH{op_b[DATA_WIDTH-1]}}, op_b});

    generate
        if (MULT_STAGES == 1) begin : g_direct
            // Operand registers only load on accept, so the product holds between results.
            assign bus.rsp_data = prod;
        end else begin : g_piped
            logic signed [PW-1:0] pdat [MULT_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < MULT_STAGES - 1; s++) begin
                        pdat[s] <= '0;
                    end
                end else begin
                    if (vld[0]) begin
                        pdat[0] <= prod;
                    end
                    for (int s = 1; s < MULT_STAGES - 1; s++) begin
                        if (vld[s]) begin
                            pdat[s] <= pdat[s-1];
                        end
                    end
                end
            end

            assign bus.rsp_data = pdat[MULT_STAGES-2];
        end
    endgenerate

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_onehot[i] = vld[MULT_STAGES-1] && (tag[MULT_STAGES-1] == TAG_W'(i));
        end
    end

    assign bus.rsp_vld = rsp_onehot;
    assign bus.busy    = |vld;

endmodule

`default_nettype wire

// File: tb/tb_eff_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_eff_mult_sched : directed and randomized checks of eff_mult_sched against
//                     a queue-based reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_eff_mult_sched;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int S  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eff_mult_sched_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    eff_mult_sched #(.N_REQ(N), .DATA_WIDTH(DW), .MULT_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [DW-1:0] a_arr [N];
    logic signed [DW-1:0] b_arr [N];
    logic [N-1:0]         vld;
    logic                 hold;
    logic [N-1:0]         acc;

    typedef struct {
        int          tag;
        logic [15:0] data;
        int          due;
    } exp_t;

    // Reference model state
    exp_t             q [$];
    int               mptr;
    int               cyc;
    logic [15:0]      last;
    logic [N-1:0]     pend;
    logic [N*DW-1:0]  pa;
    logic [N*DW-1:0]  pb;
    int               proto_viol = 0;

    function automatic logic [N-1:0] exp_grant(logic [N-1:0] v, logic h, int p);
        logic [N-1:0] r;
        r = '0;
        if (!h) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (p + k) % N;
                if (v[i] && r == '0) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] mulx(logic signed [DW-1:0] x, logic signed [DW-1:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mptr = 0;
            cyc  = 0;
            last = '0;
            pend = '0;
            pa   = '0;
            pb   = '0;
        end else begin
            logic [N-1:0] g;
            cyc++;
            while (q.size() > 0 && q[0].due < cyc) begin
                last = q[0].data;
                void'(q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i] && (!bus.req_vld[i] || bus.req_a[i*DW +: DW] != pa[i*DW +: DW]
                                || bus.req_b[i*DW +: DW] != pb[i*DW +: DW]))
                    proto_viol++;
            end
            g = exp_grant(bus.req_vld, bus.hold, mptr);
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    logic signed [DW-1:0] ta, tb;
                    ta = bus.req_a[i*DW +: DW];
                    tb = bus.req_b[i*DW +: DW];
                    q.push_back('{tag: i, data: mulx(ta, tb), due: cyc + S - 1});
                    mptr = (i + 1) % N;
                end
            end
            pend = bus.req_vld & ~g;
            pa   = bus.req_a;
            pb   = bus.req_b;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg, erv;
        logic [15:0]  ed;
        if (!rst_n) begin
            chk("rst_rdy",  32'(bus.req_rdy),  0);
            chk("rst_rsp",  32'(bus.rsp_vld),  0);
            chk("rst_data", 32'(bus.rsp_data), 0);
            chk("rst_busy", 32'(bus.busy),     0);
        end else begin
            eg  = exp_grant(bus.req_vld, bus.hold, mptr);
            erv = '0;
            ed  = last;
            if (q.size() > 0 && q[0].due == cyc) begin
                erv[q[0].tag] = 1'b1;
                ed            = q[0].data;
            end
            chk("grant",    32'(bus.req_rdy),  32'(eg));
            chk("rsp_vld",  32'(bus.rsp_vld),  32'(erv));
            chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
            chk("busy",     32'(bus.busy),     32'(q.size() > 0));
        end
    endtask

    task automatic drive();
        bus.req_vld = vld;
        bus.hold    = hold;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = a_arr[i];
            bus.req_b[i*DW +: DW] = b_arr[i];
        end
    endtask

    task automatic cyc_neg();
        @(negedge clk);
        compare();
        acc = bus.req_vld & bus.req_rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        hold = 1'b0;
        drive();
        for (int n = 0; n < 40 && vld != '0; n++) begin
            cyc_neg();
            step();
            vld &= ~acc;
            drive();
        end
        chk("drain_done", 32'(vld), 0);
    endtask

    task automatic new_op(int i);
        a_arr[i] = ($urandom % 5 == 0) ? 8'sh80 : 8'($urandom);
        b_arr[i] = ($urandom % 5 == 0) ? 8'sh7f : 8'($urandom);
    endtask

    initial begin
        vld  = '0;
        hold = 1'b0;
        acc  = '0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        drive();

        // Reset then idle
        repeat (3) cyc_neg();
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (10) cyc_neg();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_data", 32'(bus.rsp_data), 0);

        // Single requester: -3 * 25
        step();
        vld = 4'b0100; a_arr[2] = -8'sd3; b_arr[2] = 8'sd25; drive();
        cyc_neg();
        chk("single_rdy", 32'(bus.req_rdy), 32'h4);
        step(); vld = '0; drive();
        cyc_neg();
        chk("single_busy", 32'(bus.busy), 1);
        cyc_neg();
        chk("single_rsp_vld",  32'(bus.rsp_vld), 32'h4);
        chk("single_rsp_data", 32'(bus.rsp_data), 32'hFFB5);

        // Pointer wrap
        step(); vld = 4'b1000; drive();
        cyc_neg();
        chk("wrap_rdy3", 32'(bus.req_rdy), 32'h8);
        step(); vld = 4'b1001; drive();
        cyc_neg();
        chk("wrap_rdy0", 32'(bus.req_rdy), 32'h1);
        step(); vld = 4'b1000; drive();
        cyc_neg();
        chk("wrap_rdy3b", 32'(bus.req_rdy), 32'h8);
        step(); vld = '0; drive();
        repeat (3) begin cyc_neg(); step(); end

        // Full contention, then hold mid-stream
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 8'(i + 1);
            b_arr[i] = 8'sd10;
        end
        vld = 4'b1111; drive();
        repeat (12) begin cyc_neg(); step(); end
        hold = 1'b1; drive();
        repeat (5) begin
            cyc_neg();
            chk("hold_rdy", 32'(bus.req_rdy), 0);
            step();
        end
        hold = 1'b0; drive();
        repeat (6) begin cyc_neg(); step(); end
        drain();
        repeat (3) begin cyc_neg(); step(); end

        // Async reset mid-flight discards the operation
        vld = 4'b0001; a_arr[0] = 8'sh80; b_arr[0] = 8'sh80; drive();
        cyc_neg();
        step(); vld = '0; drive();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp",  32'(bus.rsp_vld),  0);
        chk("arst_busy", 32'(bus.busy),     0);
        chk("arst_data", 32'(bus.rsp_data), 0);
        cyc_neg();
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) cyc_neg();

        // Extreme products after reset
        step();
        vld = 4'b0011;
        a_arr[0] = 8'sh80; b_arr[0] = 8'sh80;
        a_arr[1] = 8'sh80; b_arr[1] = 8'sh7f;
        drive();
        cyc_neg();
        step(); vld = 4'b0010; drive();
        cyc_neg();
        step(); vld = '0; drive();
        cyc_neg();
        chk("ext_vld0",  32'(bus.rsp_vld),  32'h1);
        chk("ext_data0", 32'(bus.rsp_data), 32'h4000);
        cyc_neg();
        chk("ext_vld1",  32'(bus.rsp_vld),  32'h2);
        chk("ext_data1", 32'(bus.rsp_data), 32'hC080);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if ($urandom % 3 == 0) vld[i] = 1'b0;
                    else new_op(i);
                end else if (!vld[i] && ($urandom % 2 == 0)) begin
                    vld[i] = 1'b1;
                    new_op(i);
                end
            end
            hold = ($urandom % 8 == 0);
            drive();
            cyc_neg();
        end
        step();
        drain();
        repeat (S + 2) begin cyc_neg(); step(); end

        chk("protocol_violations", 32'(proto_viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

`default_nettype wire
